ctrl_pipe: RTL and testbench

Carries the decoded control bundle from ID down the EX/MEM/WB stage registers of the 5-stage RISC-V core and produces the pipeline's data-hazard responses. It consumes the decoder's outputs, registers them stage by stage, detects load-use hazards (stall plus bubble), and generates ALU operand forwarding selects. It sits beside the datapath stage registers; the datapath holds operand values, and this block holds control and register indices.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/fwd_unit.sv | 36 +++
 rtl/ctrl_pipe.sv | 156 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline control path.
// Decoder bundle, per-stage control slices, forwarding selects.
package ctrl_pkg;

    // Forwarding select encodings for the EX operand muxes
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Full decoder bundle for the instruction in ID
    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regWrite;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memToReg;
        logic regWrite;
    } wb_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX operand forwarding selects for rs1 and rs2.
// Ports: EX/MEM and MEM/WB regWrite/rd, ID/EX rs1/rs2 in; fwdA/fwdB out.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             exMemRegWrite_i,
    input  logic [REG_W-1:0] exMemRd_i,
    input  logic             memWbRegWrite_i,
    input  logic [REG_W-1:0] memWbRd_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o
);

    localparam logic [REG_W-1:0] X0 = REG_W'(REG_X0);

    // A producer is only eligible when it writes a real register
    logic memOk;
    logic wbOk;

    assign memOk = exMemRegWrite_i && (exMemRd_i != X0);
    assign wbOk  = memWbRegWrite_i && (memWbRd_i != X0);

    // EX/MEM holds the younger result, so it wins over MEM/WB
    assign fwdA_o = (memOk && exMemRd_i == rs1_i) ? FWD_MEM :
                    (wbOk  && memWbRd_i == rs1_i) ? FWD_WB  :
                    FWD_NONE;

    assign fwdB_o = (memOk && exMemRd_i == rs2_i) ? FWD_MEM :
                    (wbOk  && memWbRd_i == rs2_i) ? FWD_WB  :
                    FWD_NONE;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall and forwarding.
// Ports: clk_i, rst_i, freeze_i, decoder bundle in; stage controls, stall, fwd out.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             freeze_i,
    input  logic [1:0]       aluOp_i,
    input  logic             aluSrc_i,
    input  logic             memRead_i,
    input  logic             memWrite_i,
    input  logic             memToReg_i,
    input  logic             regWrite_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [REG_W-1:0] rd_i,
    output logic [1:0]       exAluOp_o,
    output logic             exAluSrc_o,
    output logic             memRead_o,
    output logic             memWrite_o,
    output logic             wbMemToReg_o,
    output logic             wbRegWrite_o,
    output logic [REG_W-1:0] wbRd_o,
    output logic             hazardStall_o,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o
);

    localparam logic [REG_W-1:0] X0 = REG_W'(REG_X0);

    ctrl_t idC;

    assign idC = '{
        aluOp:    aluOp_i,
        aluSrc:   aluSrc_i,
        memRead:  memRead_i,
        memWrite: memWrite_i,
        memToReg: memToReg_i,
        regWrite: regWrite_i
    };

    // ID/EX
    ex_ctrl_t         idExE_q,   idExE_d;
    mem_ctrl_t        idExM_q,   idExM_d;
    wb_ctrl_t         idExW_q,   idExW_d;
    logic [REG_W-1:0] idExRs1_q, idExRs1_d;
    logic [REG_W-1:0] idExRs2_q, idExRs2_d;
    logic [REG_W-1:0] idExRd_q,  idExRd_d;

    // EX/MEM
    mem_ctrl_t        exMemM_q,  exMemM_d;
    wb_ctrl_t         exMemW_q,  exMemW_d;
    logic [REG_W-1:0] exMemRd_q, exMemRd_d;

    // MEM/WB
    wb_ctrl_t         memWbW_q,  memWbW_d;
    logic [REG_W-1:0] memWbRd_q, memWbRd_d;

    logic stall;

    // Load in EX whose destination is a source of the ID instruction
    assign stall = idExM_q.memRead && (idExRd_q != X0) &&
                   ((idExRd_q == rs1_i) || (idExRd_q == rs2_i));

    always_comb begin
        idExE_d   = idExE_q;
        idExM_d   = idExM_q;
        idExW_d   = idExW_q;
        idExRs1_d = idExRs1_q;
        idExRs2_d = idExRs2_q;
        idExRd_d  = idExRd_q;
        exMemM_d  = exMemM_q;
        exMemW_d  = exMemW_q;
        exMemRd_d = exMemRd_q;
        memWbW_d  = memWbW_q;
        memWbRd_d = memWbRd_q;

        // Freeze holds everything, including a pending bubble
        if (!freeze_i) begin
            memWbW_d  = exMemW_q;
            memWbRd_d = exMemRd_q;
            exMemM_d  = idExM_q;
            exMemW_d  = idExW_q;
            exMemRd_d = idExRd_q;
            if (stall) begin
                idExE_d   = '0;
                idExM_d   = '0;
                idExW_d   = '0;
                idExRs1_d = '0;
                idExRs2_d = '0;
                idExRd_d  = '0;
            end else begin
                idExE_d   = '{aluOp: idC.aluOp, aluSrc: idC.aluSrc};
                idExM_d   = '{memRead: idC.memRead, memWrite: idC.memWrite};
                idExW_d   = '{memToReg: idC.memToReg, regWrite: idC.regWrite};
                idExRs1_d = rs1_i;
                idExRs2_d = rs2_i;
                idExRd_d  = rd_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idExE_q   <= '0;
            idExM_q   <= '0;
            idExW_q   <= '0;
            idExRs1_q <= '0;
            idExRs2_q <= '0;
            idExRd_q  <= '0;
            exMemM_q  <= '0;
            exMemW_q  <= '0;
            exMemRd_q <= '0;
            memWbW_q  <= '0;
            memWbRd_q <= '0;
        end else begin
            idExE_q   <= idExE_d;
            idExM_q   <= idExM_d;
            idExW_q   <= idExW_d;
            idExRs1_q <= idExRs1_d;
            idExRs2_q <= idExRs2_d;
            idExRd_q  <= idExRd_d;
            exMemM_q  <= exMemM_d;
            exMemW_q  <= exMemW_d;
            exMemRd_q <= exMemRd_d;
            memWbW_q  <= memWbW_d;
            memWbRd_q <= memWbRd_d;
        end
    end

    fwd_unit #(
        .REG_W(REG_W)
    ) u_fwd (
        .exMemRegWrite_i(exMemW_q.regWrite),
        .exMemRd_i      (exMemRd_q),
        .memWbRegWrite_i(memWbW_q.regWrite),
        .memWbRd_i      (memWbRd_q),
        .rs1_i          (idExRs1_q),
        .rs2_i          (idExRs2_q),
        .fwdA_o         (fwdA_o),
        .fwdB_o         (fwdB_o)
    );

    assign exAluOp_o     = idExE_q.aluOp;
    assign exAluSrc_o    = idExE_q.aluSrc;
    assign memRead_o     = exMemM_q.memRead;
    assign memWrite_o    = exMemM_q.memWrite;
    assign wbMemToReg_o  = memWbW_q.memToReg;
    assign wbRegWrite_o  = memWbW_q.regWrite;
    assign wbRd_o        = memWbRd_q;
    assign hazardStall_o = stall;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed table, corner sequences,
// and random traffic against an instruction-level pipeline model.
module tb_ctrl_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       freeze_i;
    logic [1:0] aluOp_i;
    logic       aluSrc_i, memRead_i, memWrite_i, memToReg_i, regWrite_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic [1:0] exAluOp_o;
    logic       exAluSrc_o, memRead_o, memWrite_o;
    logic       wbMemToReg_o, wbRegWrite_o;
    logic [4:0] wbRd_o;
    logic       hazardStall_o;
    logic [1:0] fwdA_o, fwdB_o;

    always #5 clk_i = ~clk_i;

    ctrl_pipe #(.REG_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i),
        .aluOp_i(aluOp_i), .aluSrc_i(aluSrc_i),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i),
        .memToReg_i(memToReg_i), .regWrite_i(regWrite_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .exAluOp_o(exAluOp_o), .exAluSrc_o(exAluSrc_o),
        .memRead_o(memRead_o), .memWrite_o(memWrite_o),
        .wbMemToReg_o(wbMemToReg_o), .wbRegWrite_o(wbRegWrite_o),
        .wbRd_o(wbRd_o), .hazardStall_o(hazardStall_o),
        .fwdA_o(fwdA_o), .fwdB_o(fwdB_o)
    );

    typedef struct packed {
        bit [1:0] op;
        bit       src, mr, mw, m2r, rw;
        bit [4:0] rs1, rs2, rd;
    } ins_t;

    typedef struct packed {
        ins_t     in;
        bit       frz;
        bit       stall;
        bit [1:0] fa, fb, op;
        bit       src, mr, wrw;
        bit [4:0] wrd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t r;
        r = '0;
        return r;
    endfunction

    function automatic ins_t lw(bit [4:0] rd, bit [4:0] rs1);
        ins_t r;
        r = '0;
        r.src = 1'b1; r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1;
        r.rd = rd; r.rs1 = rs1;
        return r;
    endfunction

    function automatic ins_t alu(bit [4:0] rd, bit [4:0] a, bit [4:0] b);
        ins_t r;
        r = '0;
        r.op = 2'b10; r.rw = 1'b1;
        r.rd = rd; r.rs1 = a; r.rs2 = b;
        return r;
    endfunction

    task automatic put(ins_t x, bit frz);
        freeze_i   = frz;
        aluOp_i    = x.op;
        aluSrc_i   = x.src;
        memRead_i  = x.mr;
        memWrite_i = x.mw;
        memToReg_i = x.m2r;
        regWrite_i = x.rw;
        rs1_i      = x.rs1;
        rs2_i      = x.rs2;
        rd_i       = x.rd;
    endtask

    function automatic vec_t v(ins_t in, bit stall, bit [1:0] fa, bit [1:0] fb,
                               bit [1:0] op, bit src, bit mr, bit wrw, bit [4:0] wrd);
        vec_t r;
        r.in = in; r.frz = 1'b0; r.stall = stall; r.fa = fa; r.fb = fb;
        r.op = op; r.src = src; r.mr = mr; r.wrw = wrw; r.wrd = wrd;
        return r;
    endfunction

    function automatic logic [16:0] all_out();
        return {exAluOp_o, exAluSrc_o, memRead_o, memWrite_o, wbMemToReg_o,
                wbRegWrite_o, wbRd_o, hazardStall_o, fwdA_o, fwdB_o};
    endfunction

    // Instruction-level model: slot 0 = EX, 1 = MEM, 2 = WB
    ins_t pipe [3];

    function automatic bit m_stall(ins_t id);
        return pipe[0].mr && pipe[0].rd != 0 &&
               (pipe[0].rd == id.rs1 || pipe[0].rd == id.rs2);
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] rs);
        if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
        if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [16:0] m_out(ins_t id);
        return {pipe[0].op, pipe[0].src, pipe[1].mr, pipe[1].mw, pipe[2].m2r,
                pipe[2].rw, pipe[2].rd, m_stall(id),
                m_fwd(pipe[0].rs1), m_fwd(pipe[0].rs2)};
    endfunction

    vec_t tbl [14];

    initial begin
        ins_t x;
        bit   frz;
        bit   st;

        // Expected values reflect stage contents before the capturing edge
        tbl[0]  = v(lw(5, 1),       0, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[1]  = v(alu(6, 5, 7),   1, 0, 0, 2'b00, 1, 0, 0, 0);
        tbl[2]  = v(alu(6, 5, 7),   0, 0, 0, 2'b00, 0, 1, 0, 0);
        tbl[3]  = v(nop(),          0, 1, 0, 2'b10, 0, 0, 1, 5);
        tbl[4]  = v(alu(3, 1, 2),   0, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[5]  = v(alu(4, 3, 3),   0, 0, 0, 2'b10, 0, 0, 1, 6);
        tbl[6]  = v(alu(3, 5, 5),   0, 2, 2, 2'b10, 0, 0, 0, 0);
        tbl[7]  = v(alu(3, 6, 6),   0, 0, 0, 2'b10, 0, 0, 1, 3);
        tbl[8]  = v(alu(8, 3, 2),   0, 0, 0, 2'b10, 0, 0, 1, 4);
        tbl[9]  = v(nop(),          0, 2, 0, 2'b10, 0, 0, 1, 3);
        tbl[10] = v(lw(0, 1),       0, 0, 0, 2'b00, 0, 0, 1, 3);
        tbl[11] = v(alu(1, 0, 0),   0, 0, 0, 2'b00, 1, 0, 1, 8);
        tbl[12] = v(nop(),          0, 0, 0, 2'b10, 0, 1, 0, 0);
        tbl[13] = v(nop(),          0, 0, 0, 2'b00, 0, 0, 1, 0);

        rst_i = 1'b1;
        put(nop(), 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_state", 32'(all_out()), 32'd0);
        rst_i = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            put(tbl[i].in, tbl[i].frz);
            #1;
            chk($sformatf("tbl%0d", i),
                32'({hazardStall_o, fwdA_o, fwdB_o, exAluOp_o, exAluSrc_o,
                     memRead_o, wbRegWrite_o, wbRd_o}),
                32'({tbl[i].stall, tbl[i].fa, tbl[i].fb, tbl[i].op,
                     tbl[i].src, tbl[i].mr, tbl[i].wrw, tbl[i].wrd}));
        end

        // Freeze during a load-use stall
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        put(lw(5, 1), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            put(alu(6, 5, 7), 1'b1);
            #1;
            chk($sformatf("frz_stall%0d", i),
                32'({hazardStall_o, exAluSrc_o, memRead_o}), 32'b110);
        end
        @(negedge clk_i);
        put(alu(6, 5, 7), 1'b0);
        #1;
        chk("frz_release", 32'({hazardStall_o, exAluSrc_o, memRead_o}), 32'b110);
        @(negedge clk_i);
        #1;
        chk("frz_bubble",
            32'({hazardStall_o, exAluOp_o, exAluSrc_o, memRead_o}), 32'b00001);

        // Reset mid-stream, then first bundle latency
        @(negedge clk_i);
        put(nop(), 1'b0);
        #1;
        chk("pre_rst_wb", 32'({wbRegWrite_o, wbRd_o}), 32'({1'b1, 5'd5}));
        rst_i = 1'b1;
        #1;
        chk("mid_rst", 32'(all_out()), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        put(alu(9, 1, 2), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_i);
            put(nop(), 1'b0);
            #1;
            chk($sformatf("rst_lat%0d", i), 32'({wbRegWrite_o, wbRd_o}),
                (i == 3) ? 32'({1'b1, 5'd9}) : 32'd0);
        end

        // Random traffic against the model
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            if (n != 0 && $urandom_range(0, 199) == 0) begin
                rst_i = 1'b1;
                for (int k = 0; k < 3; k++) pipe[k] = '0;
            end else begin
                rst_i = 1'b0;
            end
            x.op  = 2'($urandom_range(0, 3));
            x.src = 1'($urandom_range(0, 1));
            x.mr  = 1'($urandom_range(0, 1));
            x.mw  = 1'($urandom_range(0, 1));
            x.m2r = 1'($urandom_range(0, 1));
            x.rw  = 1'($urandom_range(0, 1));
            x.rs1 = 5'($urandom_range(0, 3));
            x.rs2 = 5'($urandom_range(0, 3));
            x.rd  = 5'($urandom_range(0, 3));
            frz   = ($urandom_range(0, 7) == 0);
            put(x, frz);
            #1;
            chk("rand", 32'(all_out()), 32'(m_out(x)));
            if (!rst_i && !frz) begin
                st = m_stall(x);
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = st ? '0 : x;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
